// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core constants and the requester ids of the shared adder.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        REQ_PC   = 2'd0,
        REQ_BR   = 2'd1,
        REQ_AGU  = 2'd2,
        REQ_MISC = 2'd3
    } req_id_e;

endpackage : core_pkg
`default_nettype wire

// File: rtl/adder_share_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_share_arb_if
//  Description : Requester and result handshake bundle of the shared adder.
//  Revision    : 1.0  initial release
// ============================================================================
interface adder_share_arb_if
    import core_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         res_data;
    logic                     res_carry;
    logic [ID_W-1:0]          res_id;

    // master: the requesters plus the result consumer
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_carry, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_carry, res_id
    );

endinterface : adder_share_arb_if
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin pick: first set request at or after ptr.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [ID_W-1:0]    i_ptr,
    output logic      [NUM_REQ-1:0] o_grant,
    output logic      [ID_W-1:0]    o_idx,
    output logic                    o_any
);

    logic [ID_W-1:0] w_cand;

    // Scan from the farthest offset back to ptr so the nearest valid one wins;
    // index wrap comes for free because NUM_REQ == 2**ID_W.
    always_comb begin
        w_cand  = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        o_grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = i_ptr + k[ID_W-1:0];
            if (i_req[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
        end
        if (o_any) begin
            o_grant = NUM_REQ'(1) << o_idx;
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : adder_share_arb
//  Description : Round-robin sharing of one adder among NUM_REQ requesters with a
//                single registered, id-tagged result.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_share_arb
    import core_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    adder_share_arb_if.slave bus
);

    logic [ID_W-1:0]    r_ptr;
    logic               r_res_valid;
    logic [WIDTH-1:0]   r_res_data;
    logic               r_res_carry;
    logic [ID_W-1:0]    r_res_id;

    logic               w_can_accept;
    logic [NUM_REQ-1:0] w_req_masked;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_accept;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH:0]     w_sum;

    // The output register may refill in the same cycle it drains.
    assign w_can_accept = !r_res_valid || bus.res_ready;
    assign w_req_masked = bus.req_valid & {NUM_REQ{w_can_accept && !rst}};

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req   (w_req_masked),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_accept)
    );

    assign w_a   = bus.req_a[int'(w_idx)*WIDTH +: WIDTH];
    assign w_b   = bus.req_b[int'(w_idx)*WIDTH +: WIDTH];
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_id    <= '0;
        end else if (w_accept) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_sum[WIDTH-1:0];
            r_res_carry <= w_sum[WIDTH];
            r_res_id    <= w_idx;
            r_ptr       <= w_idx + ID_W'(1);
        end else if (bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_carry = r_res_carry;
    assign bus.res_id    = r_res_id;

endmodule : adder_share_arb
`default_nettype wire

// File: tb/tb_adder_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_share_arb
//  Description : Scoreboard bench for the shared round-robin adder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adder_share_arb;
    import core_pkg::*;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam logic [63:0] C_MOD = 64'h1_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adder_share_arb_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    adder_share_arb #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             carry;
        int               id;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // reference state: pointer, whether the result register is full, last grant
    int   m_ptr   = 0;
    bit   m_valid = 1'b0;
    int   m_grant = -1;

    logic [NUM_REQ-1:0] v;
    logic [WIDTH-1:0]   a_v [NUM_REQ];
    logic [WIDTH-1:0]   b_v [NUM_REQ];
    logic               rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic apply();
        bus.req_valid = v;
        bus.res_ready = rdy;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = a_v[i];
            bus.req_b[i*WIDTH +: WIDTH] = b_v[i];
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_grant = -1;
        exp_q.delete();
    endtask

    // One clock: drive at the falling edge, predict the grant, step to the next fall.
    task automatic cycle();
        int g;
        int idx;
        logic [NUM_REQ-1:0] exp_ready;
        logic [63:0] s;
        apply();
        #1;
        chk("res_valid", 64'(bus.res_valid), 64'(m_valid));
        g = -1;
        if (!m_valid || rdy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_ready = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        m_grant = g;
        if (g >= 0) begin
            s = 64'(a_v[g]) + 64'(b_v[g]);
            exp_q.push_back('{data: WIDTH'(s % C_MOD), carry: (s >= C_MOD), id: g});
            m_ptr   = (g + 1) % NUM_REQ;
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        v = '1;
        apply();
        rst = 1'b1;
        #1;
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data",  64'(bus.res_data),  64'd0);
        chk("rst_res_carry", 64'(bus.res_carry), 64'd0);
        chk("rst_res_id",    64'(bus.res_id),    64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        v = '0;
    endtask

    // Monitor: each result transfer pops the oldest expected sum.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_data",  64'(bus.res_data),  64'(e.data));
                    chk("res_carry", 64'(bus.res_carry), 64'(e.carry));
                    chk("res_id",    64'(bus.res_id),    64'(e.id));
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] s_data;
        logic             s_carry;
        logic [ID_W-1:0]  s_id;

        v = '0;
        rdy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        @(negedge clk);
        do_reset();

        // single request from the address generator
        v = 4'b0100; a_v[2] = 32'd5; b_v[2] = 32'd7; rdy = 1'b1;
        cycle();
        chk("single_valid", 64'(bus.res_valid), 64'd1);
        chk("single_data",  64'(bus.res_data),  64'd12);
        chk("single_carry", 64'(bus.res_carry), 64'd0);
        chk("single_id",    64'(bus.res_id),    64'(REQ_AGU));

        // wrap with carry out
        v = 4'b0001; a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'h1;
        cycle();
        chk("wrap_data",  64'(bus.res_data),  64'd0);
        chk("wrap_carry", 64'(bus.res_carry), 64'd1);

        // reset while a result is held
        do_reset();

        // all requesters valid: strict rotation, one result per cycle
        v = '1; rdy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_v[i] = $urandom;
            b_v[i] = $urandom;
        end
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_valid", 64'(bus.res_valid), 64'd1);
            chk("rr_id",    64'(bus.res_id),    64'(k % NUM_REQ));
        end

        // backpressure: result held, requester 1 waits
        v = 4'b0001; a_v[0] = 32'h1234_5678; b_v[0] = 32'h9ABC_DEF0;
        cycle();
        s_data = bus.res_data; s_carry = bus.res_carry; s_id = bus.res_id;
        v = 4'b0010; a_v[1] = 32'd100; b_v[1] = 32'd23; rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_data",  64'(bus.res_data),  64'(s_data));
            chk("bp_carry", 64'(bus.res_carry), 64'(s_carry));
            chk("bp_id",    64'(bus.res_id),    64'(s_id));
        end
        rdy = 1'b1;
        cycle();
        chk("bp_release_id", 64'(bus.res_id), 64'd1);
        v = '0;
        cycle();

        // pointer skip: ptr at 3, only requester 1 valid
        v = 4'b0100; a_v[2] = 32'd1; b_v[2] = 32'd2;
        cycle();
        v = 4'b0010; a_v[1] = 32'd3; b_v[1] = 32'd4;
        cycle();
        chk("skip_id", 64'(bus.res_id), 64'd1);
        v = '1;
        cycle();
        chk("skip_ptr_next", 64'(bus.res_id), 64'd2);
        v = '0;

        // randomized traffic with random backpressure and one reset mid-run
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!v[i] && $urandom_range(0, 9) < 4) begin
                    v[i] = 1'b1;
                    a_v[i] = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
                    b_v[i] = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
                end
            end
            rdy = ($urandom_range(0, 9) < 7);
            cycle();
            if (m_grant >= 0) v[m_grant] = 1'b0;
        end

        v = '0; rdy = 1'b1;
        repeat (3) cycle();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_adder_share_arb
`default_nettype wire
